// File: rtl/spi_arbiter.sv
// ----------------------------------------------------------------------------
// Module      : spi_arbiter
// Description : Round-robin arbiter sharing one spi_master among NREQ clients,
//               with per-transfer watchdog and spi_master reset sequencing.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module spi_arbiter #(
  parameter int NREQ    = 4,
  parameter int XFER_TO = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NREQ-1:0]   req_i,
  input  logic [8*NREQ-1:0] req_din_i,
  input  logic [2*NREQ-1:0] req_mode_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   done_o,
  output logic [NREQ-1:0]   err_o,
  output logic [NREQ-1:0]   cs_n_o,
  output logic              spi_start_o,
  output logic [7:0]        spi_din_o,
  output logic [1:0]        spi_mode_o,
  output logic              spi_rst_o,
  input  logic              ss_i
);

  localparam int IW = $clog2(NREQ);
  localparam int WW = $clog2(XFER_TO);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GRANT     = 3'd1,
    S_START     = 3'd2,
    S_WAIT_LOW  = 3'd3,
    S_WAIT_HIGH = 3'd4,
    S_DONE      = 3'd5,
    S_RECOVER   = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] win_q, win_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [7:0]    din_q, din_d;
  logic [1:0]    mode_q, mode_d;
  logic          spi_rst_q;

  logic [7:0]    din_arr  [NREQ];
  logic [1:0]    mode_arr [NREQ];
  logic [IW-1:0] pick;
  logic          pick_vld;
  logic [IW:0]   rr_idx;
  logic [IW-1:0] win_inc;
  logic [NREQ-1:0] win_oh;
  logic          owns;

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign din_arr[g]  = req_din_i[8*g+7:8*g];
    assign mode_arr[g] = req_mode_i[2*g+1:2*g];
    assign cs_n_o[g]   = gnt_o[g] ? ss_i : 1'b1;
  end

  // Scan from rr upward; iterating downward lets the closest requester win last.
  always_comb begin
    pick     = rr_q;
    pick_vld = 1'b0;
    rr_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      rr_idx = {1'b0, rr_q} + (IW+1)'(k);
      if (rr_idx >= (IW+1)'(NREQ)) begin
        rr_idx = rr_idx - (IW+1)'(NREQ);
      end
      if (req_i[rr_idx[IW-1:0]]) begin
        pick     = rr_idx[IW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  assign win_inc = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    wd_d    = wd_q;
    din_d   = din_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          win_d   = pick;
          din_d   = din_arr[pick];
          mode_d  = mode_arr[pick];
          state_d = S_GRANT;
        end
      end
      S_GRANT: state_d = S_START;
      S_START: begin
        wd_d    = '0;
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW, S_WAIT_HIGH: begin
        wd_d = wd_q + WW'(1);
        // Watchdog wins over SS so a stuck slave-select cannot hang the bus.
        if (wd_q == WW'(XFER_TO - 1)) begin
          state_d = S_RECOVER;
        end else if (state_q == S_WAIT_LOW && !ss_i) begin
          state_d = S_WAIT_HIGH;
        end else if (state_q == S_WAIT_HIGH && ss_i) begin
          state_d = S_DONE;
        end
      end
      S_DONE, S_RECOVER: begin
        rr_d    = win_inc;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      win_q     <= '0;
      wd_q      <= '0;
      din_q     <= '0;
      mode_q    <= '0;
      spi_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      win_q     <= win_d;
      wd_q      <= wd_d;
      din_q     <= din_d;
      mode_q    <= mode_d;
      spi_rst_q <= (state_d == S_RECOVER);
    end
  end

  assign win_oh      = NREQ'(1) << win_q;
  assign owns        = (state_q inside {S_GRANT, S_START, S_WAIT_LOW, S_WAIT_HIGH});
  assign gnt_o       = owns ? win_oh : '0;
  assign done_o      = (state_q == S_DONE) ? win_oh : '0;
  assign err_o       = (state_q == S_RECOVER) ? win_oh : '0;
  assign spi_start_o = (state_q == S_START);
  assign spi_din_o   = din_q;
  assign spi_mode_o  = mode_q;
  assign spi_rst_o   = spi_rst_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_arbiter.sv
// ----------------------------------------------------------------------------
// Module      : tb_spi_arbiter
// Description : Self-checking bench for spi_arbiter with a behavioural SPI slave.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_spi_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_din;
  logic [7:0]  req_mode;
  logic [3:0]  gnt, done, err, cs_n;
  logic        spi_start, spi_rst, ss;
  logic [7:0]  spi_din;
  logic [1:0]  spi_mode;
  bit          ss_stuck;

  int n_chk  = 0;
  int n_pass = 0;
  int n_inv_print = 0;

  spi_arbiter #(.NREQ(4), .XFER_TO(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .req_din_i   (req_din),
    .req_mode_i  (req_mode),
    .gnt_o       (gnt),
    .done_o      (done),
    .err_o       (err),
    .cs_n_o      (cs_n),
    .spi_start_o (spi_start),
    .spi_din_o   (spi_din),
    .spi_mode_o  (spi_mode),
    .spi_rst_o   (spi_rst),
    .ss_i        (ss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // spi_master stand-in: SS falls one cycle after start, stays low 17 cycles.
  initial begin
    ss = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && spi_start && !ss_stuck) begin
        @(negedge clk);
        ss = 1'b0;
        repeat (17) @(negedge clk);
        ss = 1'b1;
      end
    end
  end

  typedef struct {
    int         sidx;
    int         eidx;
    int         lat;
    int         low;
    int         rst;
    logic [7:0] din;
    logic [1:0] mode;
    bit         is_err;
    bit         timeout;
  } xfer_t;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] din;
    logic [7:0]  mode;
    int          exp_idx;
    logic [7:0]  exp_din;
    logic [1:0]  exp_mode;
  } vec_t;

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference arbitration: first set request at or after the pointer, circularly.
  function automatic int ref_pick(input logic [3:0] r, input int ptr);
    for (int k = 0; k < 4; k++) if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Per-cycle structural properties of the outputs.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      begin
        logic [3:0] exp_cs;
        bit ok;
        for (int i = 0; i < 4; i++) exp_cs[i] = gnt[i] ? ss : 1'b1;
        ok = $onehot0(gnt) && $onehot0(done) && $onehot0(err) &&
             !((|done) && (|err)) && (cs_n == exp_cs) && (!spi_start || (gnt != 0));
        n_chk++;
        if (ok) n_pass++;
        else if (n_inv_print < 10) begin
          n_inv_print++;
          $display("FAIL invariant @%0t: gnt=%b done=%b err=%b cs_n=%b (expected cs_n=%b) start=%b",
                   $time, gnt, done, err, cs_n, exp_cs, spi_start);
        end
      end
    end
  end

  task automatic wait_xfer(output xfer_t r);
    bit started;
    started   = 0;
    r.sidx    = -1;
    r.eidx    = -1;
    r.lat     = 0;
    r.low     = 0;
    r.rst     = 0;
    r.din     = '0;
    r.mode    = '0;
    r.is_err  = 0;
    r.timeout = 1;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      if (spi_start && !started) begin
        started = 1;
        r.sidx  = oh2i(gnt);
        r.din   = spi_din;
        r.mode  = spi_mode;
      end else if (started) begin
        r.lat++;
      end
      if (started && r.sidx >= 0 && cs_n[r.sidx] == 1'b0) r.low++;
      if (started && spi_rst) r.rst++;
      if (started && (done != 0 || err != 0)) begin
        r.eidx    = oh2i(done | err);
        r.is_err  = (err != 0);
        r.timeout = 0;
        break;
      end
    end
    n_chk++;
    if (!r.timeout) n_pass++;
    else $display("FAIL xfer_timeout: got no done/err within 300 cycles, expected completion");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " gnt"}, gnt, 4'h0);
    chk({tag, " done"}, done, 4'h0);
    chk({tag, " err"}, err, 4'h0);
    chk({tag, " spi_start"}, spi_start, 1'b0);
    chk({tag, " spi_din"}, spi_din, 8'h00);
    chk({tag, " spi_mode"}, spi_mode, 2'b00);
    chk({tag, " spi_rst"}, spi_rst, 1'b1);
    chk({tag, " cs_n"}, cs_n, 4'hF);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_one(input string tag, input logic [3:0] r, input int exp_idx);
    xfer_t x;
    req = r;
    wait_xfer(x);
    req = 4'h0;
    chk({tag, " grant"}, x.sidx, exp_idx);
    chk({tag, " done idx"}, x.eidx, exp_idx);
    chk({tag, " is_err"}, x.is_err, 1'b0);
  endtask

  vec_t  tbl [8];
  xfer_t x;

  initial begin
    int rr_m;
    int bad;
    bit seen;

    tbl[0] = '{4'b0001, 32'h11223344, 8'b00_01_10_11, 0, 8'h44, 2'b11};
    tbl[1] = '{4'b0011, 32'hDEADBEEF, 8'b11_10_01_00, 1, 8'hBE, 2'b01};
    tbl[2] = '{4'b1001, 32'h01020304, 8'b10_00_00_01, 3, 8'h01, 2'b10};
    tbl[3] = '{4'b0110, 32'hCAFEF00D, 8'b00_11_10_01, 1, 8'hF0, 2'b10};
    tbl[4] = '{4'b0001, 32'h55AA55AA, 8'b01_01_01_10, 0, 8'hAA, 2'b10};
    tbl[5] = '{4'b1100, 32'h98765432, 8'b11_01_00_00, 2, 8'h76, 2'b01};
    tbl[6] = '{4'b0101, 32'h0F1E2D3C, 8'b00_10_00_11, 0, 8'h3C, 2'b11};
    tbl[7] = '{4'b1000, 32'hA1B2C3D4, 8'b01_00_00_00, 3, 8'hA1, 2'b01};

    rst_n = 1'b0; req = '0; req_din = '0; req_mode = '0; ss_stuck = 0;

    // Reset values and spi_rst release sequencing
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("spi_rst held after release", spi_rst, 1'b1);
    @(posedge clk);
    #1;
    chk("spi_rst low after one edge", spi_rst, 1'b0);

    // Single request
    req = 4'b0001; req_din = 32'h000000A5; req_mode = 8'h00;
    wait_xfer(x);
    req = 4'h0;
    chk("single grant", x.sidx, 0);
    chk("single spi_din", x.din, 8'hA5);
    chk("single spi_mode", x.mode, 2'b00);
    chk("single ss low cycles", x.low, 17);
    chk("single start->done", x.lat, 19);
    chk("single done idx", x.eidx, 0);
    chk("single is_err", x.is_err, 1'b0);

    // Table vectors from a known pointer
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req = tbl[i].req; req_din = tbl[i].din; req_mode = tbl[i].mode;
      wait_xfer(x);
      req = 4'h0;
      chk($sformatf("vec%0d grant", i), x.sidx, tbl[i].exp_idx);
      chk($sformatf("vec%0d din", i), x.din, tbl[i].exp_din);
      chk($sformatf("vec%0d mode", i), x.mode, tbl[i].exp_mode);
      chk($sformatf("vec%0d done idx", i), x.eidx, tbl[i].exp_idx);
      chk($sformatf("vec%0d is_err", i), x.is_err, 1'b0);
    end

    // Contention with all requests held
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_xfer(x);
      chk($sformatf("contend%0d grant", i), x.sidx, i % 4);
      chk($sformatf("contend%0d done idx", i), x.eidx, i % 4);
      chk($sformatf("contend%0d is_err", i), x.is_err, 1'b0);
    end
    req = 4'h0;

    // Data stability: requester 1 changes its byte mid-transfer
    req = 4'b0010; req_din = 32'h00003C00; req_mode = 8'b0000_1000;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (spi_start) begin seen = 1; break; end
    end
    chk("stab start seen", seen, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    req_din = 32'h0000FF00;
    bad = 0; seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (spi_din !== 8'h3C) bad++;
      if (done != 0) begin seen = 1; break; end
    end
    req = 4'h0;
    chk("stab din changes", bad, 0);
    chk("stab done[1]", done, 4'b0010);
    chk("stab spi_mode", spi_mode, 2'b10);

    // Watchdog with SS stuck high
    ss_stuck = 1;
    req = 4'b0100;
    wait_xfer(x);
    req = 4'h0;
    chk("wdog grant", x.sidx, 2);
    chk("wdog is_err", x.is_err, 1'b1);
    chk("wdog err idx", x.eidx, 2);
    chk("wdog start->err", x.lat, 33);
    chk("wdog spi_rst cycles", x.rst, 1);
    @(posedge clk); #1;
    chk("wdog spi_rst drops", spi_rst, 1'b0);
    ss_stuck = 0;
    run_one("wdog rr advance", 4'b1100, 3);

    // Reset mid-transfer
    run_one("pre-abort", 4'b0010, 1);
    req = 4'b1000;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (spi_start) begin seen = 1; break; end
    end
    chk("abort start seen", seen, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    req = 4'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort spi_rst after release", spi_rst, 1'b1);
    @(posedge clk); #1;
    chk("abort spi_rst low", spi_rst, 1'b0);
    for (int c = 0; c < 40 && ss !== 1'b1; c++) @(posedge clk);
    run_one("post-abort rr=0", 4'b0101, 0);
    run_one("post-abort req2", 4'b0100, 2);

    // Owner drops request during WAIT_LOW
    req = 4'b0100;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (spi_start) begin seen = 1; break; end
    end
    chk("drop start seen", seen, 1'b1);
    @(posedge clk); #1;
    req = 4'h0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (done != 0 || err != 0) break;
    end
    chk("drop done", done, 4'b0100);
    chk("drop err", err, 4'b0000);
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (gnt != 0) bad++;
    end
    chk("drop no regrant", bad, 0);

    // Randomised transfers against the reference arbitration model
    do_reset();
    rr_m = 0;
    for (int t = 0; t < 20; t++) begin
      logic [3:0]  pat;
      logic [31:0] d;
      logic [7:0]  m;
      bit          stuck;
      int          w;
      pat   = 4'($urandom_range(1, 15));
      d     = $urandom;
      m     = 8'($urandom);
      stuck = ($urandom_range(0, 7) == 0);
      w     = ref_pick(pat, rr_m);
      ss_stuck = stuck;
      req = pat; req_din = d; req_mode = m;
      wait_xfer(x);
      req = 4'h0;
      ss_stuck = 0;
      chk($sformatf("rnd%0d grant", t), x.sidx, w);
      chk($sformatf("rnd%0d din", t), x.din, d[8*w +: 8]);
      chk($sformatf("rnd%0d mode", t), x.mode, m[2*w +: 2]);
      chk($sformatf("rnd%0d end idx", t), x.eidx, w);
      chk($sformatf("rnd%0d is_err", t), x.is_err, stuck);
      chk($sformatf("rnd%0d latency", t), x.lat, stuck ? 33 : 19);
      rr_m = (w + 1) % 4;
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NREQ, default 4, gives the number of requesters sharing one spi_master; legal range is 2..8.
REQ-002 Parameter XFER_TO, default 32, gives the watchdog limit in clk cycles from spi_start to SS return-high.
REQ-003 clk  input  1  is the single clock; all logic is on its rising edge.
REQ-004 reset  input  1  is an asynchronous, active-low reset.
REQ-005 req  input  NREQ  is the per-requester transfer request, level, held until done.
REQ-006 req_din  input  8*NREQ  is the per-requester byte; slice i is [8i+7:8i].
REQ-007 req_mode  input  2*NREQ  is the per-requester SPI mode; slice i is [2i+1:2i].
REQ-008 gnt  output  NREQ  is one-hot and marks the owner of the SPI master.
REQ-009 done  output  NREQ  is a one-cycle pulse to the owner when its transfer completes.
REQ-010 err  output  NREQ  is a one-cycle pulse to the owner when the watchdog expires.
REQ-011 cs_n  output  NREQ  is the per-slave chip select: cs_n[i] = SS when gnt[i]=1, else 1.
REQ-012 spi_start  output  1  drives the start input of spi_master.
REQ-013 spi_din  output  8  drives the din input of spi_master.
REQ-014 spi_mode  output  2  drives the mode input of spi_master.
REQ-015 spi_rst  output  1  drives spi_master's active-high synchronous reset.
REQ-016 SS  input  1  is spi_master's slave-select, active-low, which frames a transfer.

Function
REQ-017 The FSM has the states IDLE, GRANT, START, WAIT_LOW, WAIT_HIGH, DONE and RECOVER.
REQ-018 IDLE behaviour:
- when req is nonzero, select the winner by round-robin starting from pointer rr, and go to GRANT;
- when req is zero, stay in IDLE.
REQ-019 GRANT behaviour:
- assert gnt[winner];
- latch req_din and req_mode of the winner into spi_din and spi_mode;
- go to START.
REQ-020 spi_din and spi_mode remain constant from GRANT until the FSM returns to IDLE; input changes during a transfer are ignored.
REQ-021 START asserts spi_start for exactly one cycle, then goes to WAIT_LOW.
REQ-022 WAIT_LOW waits for SS=0, then goes to WAIT_HIGH.
REQ-023 WAIT_HIGH waits for SS=1, then goes to DONE.
REQ-024 DONE behaviour:
- pulse done[winner] for one cycle;
- set rr = winner+1, wrapping NREQ-1 to 0;
- clear gnt;
- go to IDLE.
REQ-025 A watchdog counter clears in START and increments every cycle in WAIT_LOW and WAIT_HIGH.
REQ-026 When the watchdog counter reaches XFER_TO-1, the FSM goes to RECOVER regardless of SS.
REQ-027 RECOVER behaviour:
- assert spi_rst for one cycle;
- pulse err[winner], with no done pulse;
- advance rr as in DONE;
- clear gnt;
- go to IDLE.
REQ-028 A nominal transfer takes 19 cycles from spi_start to SS return-high; XFER_TO shall exceed 19.
REQ-029 If the owner drops req mid-transfer, the transfer still completes and done still pulses.
REQ-030 A requester that still holds req after done is not regranted while any other req bit is set.
REQ-031 With one requester active, grants are back-to-back, with a minimum of 3 IDLE/GRANT cycles between transfers.
REQ-032 gnt, done and err are each one-hot or zero in every cycle.
REQ-033 done and err are never asserted in the same cycle.
REQ-034 spi_start is asserted only in START.
REQ-035 spi_rst is asserted only in RECOVER and during the reset window.

Reset
REQ-036 While reset=0, the block is held in its reset values:
- state=IDLE, rr=0, watchdog=0;
- gnt=0, done=0, err=0, spi_start=0;
- spi_din=0, spi_mode=0, spi_rst=1.
REQ-037 After reset deasserts, spi_rst stays at 1 for one further clk cycle and is then 0, so that spi_master executes its own reset state.
REQ-038 Reset asserted mid-transfer takes effect immediately:
- outputs go to their reset values;
- no done or err pulse is issued for the aborted transfer.
REQ-039 cs_n is all ones during reset.

Verification
REQ-040 Single request: req=0001, req_din[7:0]=8'hA5, mode 0 -> gnt=0001, and one spi_start pulse with spi_din=8'hA5. SS low for 17 cycles, then done[0] pulses, and cs_n[0] tracks SS.
REQ-041 Contention: req=1111 held, rr=0 -> grant order 0,1,2,3,0, with exactly one done per grant and gnt never multi-hot.
REQ-042 Data stability: change req_din[15:8] from 8'h3C to 8'hFF during requester 1's WAIT_HIGH -> spi_din stays 8'h3C until done[1].
REQ-043 Watchdog: SS held at 1 after spi_start, XFER_TO=32 -> err[winner] pulses, spi_rst=1 for one cycle, no done, and rr advances.
REQ-044 Reset mid-transfer: assert reset=0 in WAIT_HIGH -> outputs match REQ-036 immediately. After release, spi_rst=1 for one cycle, and a new req=0100 is granted with rr=0 logic.
REQ-045 Request drop: requester 2 deasserts req during WAIT_LOW -> the transfer completes, done[2] pulses, and no new grant to 2 follows.
